// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/execute controller feeding the register-file/ALU datapath.
// Fetches 16-bit instructions from synchronous memory into an instruction register, sequences
// LOAD/STORE accesses, latches ALU flags and resolves PC-relative conditional branches.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   mem_rdata    memory read data (valid one cycle after mem_addr)
//   alu_flags    ALU flag word, bits [4:0] = {Z,C,F,L,N}
//   reg_a        datapath read port A (Rsrc, IR[7:4])
//   reg_b        datapath read port B (IR[3:0])
//   instruction  current IR to the datapath
//   ren          register-write enable
//   load_sel     bus source: 00 ALU, 01 memory, 10 controller
//   mem_addr     memory address
//   mem_wdata    memory write data
//   mem_we       memory write strobe
//   pc           program counter
//   flags_q      latched {Z,C,F,L,N}
//   halted       trap indicator
//
// Optional feature: define ILLEGAL_TRAP_EN to trap undefined opcodes into a HALT state that only
// reset leaves. Without it, undefined opcodes execute as NOP and halted is always 0.

module instr_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_WORD = 16'h1700
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_rdata,
  input  logic [15:0] alu_flags,
  input  logic [15:0] reg_a,
  input  logic [15:0] reg_b,
  output logic [15:0] instruction,
  output logic        ren,
  output logic [1:0]  load_sel,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic [15:0] pc,
  output logic [4:0]  flags_q,
  output logic        halted
);

  localparam int unsigned W  = 16;
  localparam int unsigned FW = 5;

  localparam logic [7:0] OP_ALU_MAX  = 8'h16;
  localparam logic [7:0] OP_FLAG_MAX = 8'h0C;
  localparam logic [7:0] OP_NOP      = 8'h17;
  localparam logic [7:0] OP_LOAD     = 8'h99;
  localparam logic [7:0] OP_STORE    = 8'hDA;
  localparam logic [7:0] OP_CTLST    = 8'h80;
  localparam logic [3:0] OP_BRANCH   = 4'hC;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_CTL = 2'b10;

`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {FETCH, FWAIT, EXEC, MEMRD, HALT} state_t;
`else
  typedef enum logic [2:0] {FETCH, FWAIT, EXEC, MEMRD} state_t;
`endif

  state_t         state, state_next;
  logic [W-1:0]   ir, ir_next, pc_next;
  logic [FW-1:0]  flags_next;
  logic [7:0]     opcode;
  logic [W-1:0]   disp;
  logic           cond_true;
  logic           unused_flags;

  assign unused_flags = ^alu_flags[15:FW];
  assign opcode       = ir[15:8];
  assign disp         = {{8{ir[7]}}, ir[7:0]};

  // Branch condition from the flags as latched now; flags_q = {Z,C,F,L,N}.
  always_comb begin
    cond_true = 1'b0;
    case (ir[11:8])
      4'h0:    cond_true =  flags_q[4];
      4'h1:    cond_true = !flags_q[4];
      4'h2:    cond_true =  flags_q[3];
      4'h3:    cond_true = !flags_q[3];
      4'h4:    cond_true =  flags_q[2];
      4'h5:    cond_true =  flags_q[1];
      4'h6:    cond_true =  flags_q[0];
      4'h7:    cond_true = !flags_q[0];
      4'hE:    cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // State and architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= NOP_WORD;
      flags_q <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      ir      <= ir_next;
      flags_q <= flags_next;
    end
  end

  // Next-state, register updates and datapath controls.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    ir_next     = ir;
    flags_next  = flags_q;
    ren         = 1'b0;
    mem_we      = 1'b0;
    load_sel    = SEL_ALU;
    mem_wdata   = reg_a;
    instruction = ir;
    mem_addr    = pc;
    halted      = 1'b0;

    case (state)
      FETCH: state_next = FWAIT;
      FWAIT: begin
        ir_next    = mem_rdata;
        pc_next    = pc + W'(1);
        state_next = EXEC;
      end
      EXEC: begin
        state_next = FETCH;
        if (opcode <= OP_ALU_MAX) begin
          ren = 1'b1;
          if (opcode <= OP_FLAG_MAX) flags_next = alu_flags[FW-1:0];
        end else if (opcode == OP_NOP) begin
          ren = 1'b0;
        end else if (opcode == OP_LOAD) begin
          mem_addr   = reg_a;
          state_next = MEMRD;
        end else if (opcode == OP_STORE) begin
          mem_addr = reg_b;
          mem_we   = 1'b1;
        end else if (opcode == OP_CTLST) begin
          ren      = 1'b1;
          load_sel = SEL_CTL;
        end else if (opcode[7:4] == OP_BRANCH) begin
          // pc already points past the branch, so the displacement is relative to addr+1.
          if (cond_true) pc_next = pc + disp;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_next = HALT;
          ir_next    = NOP_WORD;
`else
          ren = 1'b0;
`endif
        end
      end
      MEMRD: begin
        mem_addr   = reg_a;
        ren        = 1'b1;
        load_sel   = SEL_MEM;
        state_next = FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      HALT: begin
        halted     = 1'b1;
        state_next = HALT;
      end
`endif
      default: state_next = FETCH;
    endcase

    // No register or memory write may land while reset is asserted.
    if (reset) begin
      ren    = 1'b0;
      mem_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes expected datapath write events
// (ren or mem_we cycles) into a queue; a monitor pops and compares each observed event.
module tb_instr_sequencer;

  typedef struct packed {
    logic [15:0] instr;
    logic        ren;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [15:0] wdata;
  } ev_t;

  logic        clk;
  logic        reset;
  logic [15:0] mem_rdata;
  logic [15:0] alu_flags;
  logic [15:0] reg_a;
  logic [15:0] reg_b;
  logic [15:0] instruction;
  logic        ren;
  logic [1:0]  load_sel;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] pc;
  logic [4:0]  flags_q;
  logic        halted;

  logic [15:0] mem [0:65535];
  ev_t         exp_q [$];
  int          tests;
  int          fails;

  instr_sequencer #(.RESET_PC(16'h0000), .NOP_WORD(16'h1700)) dut (
    .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .alu_flags(alu_flags),
    .reg_a(reg_a), .reg_b(reg_b), .instruction(instruction), .ren(ren),
    .load_sel(load_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .pc(pc), .flags_q(flags_q), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Synchronous memory: read data one cycle after address, write on mem_we.
  task automatic mem_model();
    forever begin
      @(posedge clk);
      mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  endtask

  task automatic monitor();
    ev_t got;
    ev_t want;
    forever begin
      @(negedge clk);
      if (ren || mem_we) begin
        got = {instruction, ren, mem_we, load_sel, mem_addr, mem_wdata};
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: got %0h expected none", got);
        end else begin
          want = exp_q.pop_front();
          check("event", 64'(got), 64'(want));
        end
      end
    end
  endtask

  task automatic push(input logic [15:0] i, input logic r, input logic w, input logic [1:0] s,
                      input logic [15:0] a);
    ev_t e;
    e = {i, r, w, s, a, reg_a};
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_prog(input logic [15:0] ra, input logic [15:0] rb, input logic [15:0] fl);
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    reg_a = ra;
    reg_b = rb;
    alu_flags = fl;
  endtask

  // Leaves the DUT in its first FETCH cycle, 1 time unit after the edge.
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_pc", 64'(pc), 64'(16'h0000));
    check("rst_ir", 64'(instruction), 64'(16'h1700));
    check("rst_flags", 64'(flags_q), 64'(5'h00));
    check("rst_halted", 64'(halted), 64'(1'b0));
  endtask

  task automatic end_prog(input string name);
    check(name, 64'(exp_q.size()), 64'(0));
    reset = 1'b1;
  endtask

  task automatic branch_run(input logic [15:0] br, input logic [15:0] exp_pc);
    start_prog(16'h0000, 16'h0000, 16'h0010);
    mem[0] = 16'h0A12;
    mem[1] = 16'h1000;
    mem[2] = 16'h1700;
    mem[3] = 16'h1700;
    mem[4] = 16'h1700;
    mem[5] = br;
    push(16'h0A12, 1'b1, 1'b0, 2'b00, 16'h0001);
    push(16'h1000, 1'b1, 1'b0, 2'b00, 16'h0002);
    do_reset();
    step(3);
    check("cmp_flags", 64'(flags_q), 64'(5'b10000));
    alu_flags = 16'h0000;
    step(3);
    check("nonflag_alu_keeps_flags", 64'(flags_q), 64'(5'b10000));
    step(12);
    check("branch_pc", 64'(pc), 64'(exp_pc));
    check("branch_fetch_addr", 64'(mem_addr), 64'(exp_pc));
    end_prog("branch_q_empty");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    reg_a = 16'h0000;
    reg_b = 16'h0000;
    alu_flags = 16'h0000;
    fork
      mem_model();
      monitor();
    join_none

    // ALU op with flag latch
    start_prog(16'h1111, 16'h2222, 16'h0005);
    mem[0] = 16'h0012;
    push(16'h0012, 1'b1, 1'b0, 2'b00, 16'h0001);
    do_reset();
    check("alu_fetch_addr", 64'(mem_addr), 64'(16'h0000));
    step(1);
    check("alu_fwait_addr", 64'(mem_addr), 64'(16'h0000));
    step(1);
    check("alu_exec_pc", 64'(pc), 64'(16'h0001));
    check("alu_exec_ir", 64'(instruction), 64'(16'h0012));
    step(1);
    check("alu_next_fetch", 64'(mem_addr), 64'(16'h0001));
    check("alu_flags", 64'(flags_q), 64'(5'h05));
    end_prog("alu_q_empty");

    // LOAD
    start_prog(16'h0040, 16'h0003, 16'h0000);
    mem[0] = 16'h9934;
    push(16'h9934, 1'b1, 1'b0, 2'b01, 16'h0040);
    do_reset();
    step(2);
    check("load_exec_addr", 64'(mem_addr), 64'(16'h0040));
    check("load_exec_ren", 64'(ren), 64'(1'b0));
    step(1);
    check("load_memrd_addr", 64'(mem_addr), 64'(16'h0040));
    step(1);
    check("load_back_fetch", 64'(mem_addr), 64'(16'h0001));
    end_prog("load_q_empty");

    // STORE
    start_prog(16'hBEEF, 16'h0100, 16'h0000);
    mem[0] = 16'hDA56;
    push(16'hDA56, 1'b0, 1'b1, 2'b00, 16'h0100);
    do_reset();
    step(3);
    check("store_we_drop", 64'(mem_we), 64'(1'b0));
    check("store_next_fetch", 64'(mem_addr), 64'(16'h0001));
    check("store_mem", 64'(mem[16'h0100]), 64'(16'hBEEF));
    end_prog("store_q_empty");

    // Compare then branch on Z / !Z
    branch_run(16'hC0FC, 16'h0002);
    branch_run(16'hC1FC, 16'h0006);

    // CTLST, never-taken branch, always-taken branch to FFFF, pc wrap
    start_prog(16'h7777, 16'h0000, 16'h001F);
    mem[0] = 16'h8012;
    mem[1] = 16'hC805;
    mem[2] = 16'hCEFC;
    mem[16'hFFFF] = 16'h1700;
    push(16'h8012, 1'b1, 1'b0, 2'b10, 16'h0001);
    do_reset();
    step(6);
    check("never_branch_addr", 64'(mem_addr), 64'(16'h0002));
    step(3);
    check("always_branch_addr", 64'(mem_addr), 64'(16'hFFFF));
    step(2);
    check("wrap_pc", 64'(pc), 64'(16'h0000));
    step(1);
    check("wrap_fetch", 64'(mem_addr), 64'(16'h0000));
    end_prog("ctl_q_empty");

    // Reset during STORE EXEC
    start_prog(16'hBEEF, 16'h0100, 16'h0000);
    mem[0] = 16'hDA56;
    do_reset();
    step(2);
    reset = 1'b1;
    #1;
    check("rst_store_we", 64'(mem_we), 64'(1'b0));
    check("rst_store_ren", 64'(ren), 64'(1'b0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_store_addr", 64'(mem_addr), 64'(16'h0000));
    check("rst_store_ir", 64'(instruction), 64'(16'h1700));
    check("rst_store_mem", 64'(mem[16'h0100]), 64'(16'h0000));
    end_prog("rst_q_empty");

    // Undefined opcode
    start_prog(16'h0000, 16'h0000, 16'h0000);
    mem[0] = 16'h2000;
    mem[1] = 16'h0012;
`ifdef ILLEGAL_TRAP_EN
    do_reset();
    step(3);
    check("trap_halted", 64'(halted), 64'(1'b1));
    check("trap_pc", 64'(pc), 64'(16'h0001));
    check("trap_ir", 64'(instruction), 64'(16'h1700));
    step(3);
    check("trap_still_halted", 64'(halted), 64'(1'b1));
    check("trap_pc_frozen", 64'(pc), 64'(16'h0001));
`else
    push(16'h0012, 1'b1, 1'b0, 2'b00, 16'h0002);
    do_reset();
    step(3);
    check("undef_halted", 64'(halted), 64'(1'b0));
    check("undef_next_fetch", 64'(mem_addr), 64'(16'h0001));
    step(3);
    check("undef_after_pc", 64'(pc), 64'(16'h0002));
`endif
    end_prog("undef_q_empty");

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
